ram_mfa_moc: RTL
================

Name: ram_mfa_moc

Overview:
Byte-addressable, big-endian main memory that the datapath control unit talks to over an MFA/MOC handshake. It serves instruction fetch and load/store accesses of byte, halfword or word size. Access latency is programmable so the control FSM's wait states are exercised. Storage is a byte array named Mem; benches preload it hierarchically.

Parameters:
ADDR_W, 9, byte-address width; depth = 2**ADDR_W bytes (512)
LATENCY, 2, clock edges from MFA acceptance to MOC assertion; legal range 1..15

Ports:
Clk  input  1  system clock, rising-edge
Clear  input  1  reset, asynchronous, active-high
MFA  input  1  memory function activate; request strobe from control unit
RW  input  1  1 = read, 0 = write
DT  input  2  data type: 00 byte, 01 halfword, 10 word, 11 treated as word
SE  input  1  sign-extend byte/halfword reads (1) or zero-extend (0)
Addr  input  ADDR_W  byte address of the access
DataIn  input  32  write data, right-justified
DataOut  output  32  read data, right-justified, held until next read completes
MOC  output  1  memory operation complete
Err  output  1  misaligned access flag, valid while MOC=1

Behaviour:
- Reset (Clear=1, async): state=IDLE, MOC=0, Err=0, DataOut=0, count=0. Mem contents are not cleared.
- Reset mid-access aborts the access: no write is committed, and MOC does not assert.
- FSM states: IDLE, BUSY, DONE.
- IDLE: at the edge where MFA=1, latch Addr/RW/DT/SE/DataIn, clear count, then go to BUSY.
- BUSY: count increments each edge. At the edge where count==LATENCY-1, perform the access, set MOC=1 and go to DONE.
- Timing: with MFA accepted at edge k, the access commits and MOC rises at edge k+LATENCY.
- DONE: MOC stays 1 while MFA=1. At the first edge with MFA=0, MOC=0, Err=0, and the FSM returns to IDLE. A new request cannot be accepted earlier than the edge after that.
- MFA dropping during BUSY does not cancel the access. The access completes, and MOC is high for exactly one cycle.
- Inputs changing during BUSY/DONE are ignored; only the latched copies are used.
- Big-endian mapping: the byte at Addr is most significant.
  - word = {Mem[A],Mem[A+1],Mem[A+2],Mem[A+3]}
  - halfword = {Mem[A],Mem[A+1]}
- Reads:
  - Byte/halfword results are right-justified in DataOut and extended per SE.
  - Mem is unchanged.
- Writes:
  - Byte writes DataIn[7:0]; halfword writes DataIn[15:0]; word writes all 32 bits.
  - DataOut is unchanged.
- Alignment:
  - A halfword with A[0]=1, or a word with A[1:0]!=0, is misaligned.
  - A misaligned access performs no write, leaves DataOut unchanged, and sets Err=1 together with MOC.
  - Byte accesses are always aligned.
- Addresses are ADDR_W bits wide, so A+n wraps modulo depth. This only matters for aligned accesses at the top of memory, which do not actually cross the boundary.
- Only one access is in flight at a time; there is no queuing.

Decomposition:
- Shared package (mem_pkg):
  - DT encodings DT_BYTE=2'b00, DT_HALF=2'b01, DT_WORD=2'b10
  - FSM state encodings S_IDLE/S_BUSY/S_DONE
  - RW_READ=1 and RW_WRITE=0
- Sub-module mem_align: combinational lane steering, extension and misalignment detection. Inputs are DT, SE, Addr[1:0] and the raw bytes; outputs are the read word, byte write enables and Err. The top module keeps the FSM, counter and Mem array.

Test Plan:
- Preload Mem[0..3]=8'h12,8'h34,8'h56,8'h78. Read word @0 with LATENCY=2 and MFA raised at edge k -> MOC rises at edge k+2, DataOut=32'h12345678, Err=0, and MOC stays high until MFA drops.
- Read byte @3 with SE=1 where Mem[3]=8'h80 -> DataOut=32'hFFFFFF80. Repeat with SE=0 -> 32'h00000080. Read halfword @2 with Mem[2..3]=8'h56,8'h78 -> 32'h00005678.
- Write word 32'hDEADBEEF @8, then write byte 8'hAA @9 -> Mem[8..11]=DE,AA,BE,EF. A word read @8 returns 32'hDEAABEEF, and DataOut is unchanged after each write.
- Word read @2 and halfword write @5 -> Err=1 with MOC, Mem unchanged, DataOut keeps its prior value. Err clears when MOC drops.
- Drop MFA one cycle after acceptance -> the write still commits and MOC is high for exactly one cycle. Assert Clear during BUSY of a write @16 -> Mem[16..19] unchanged, MOC=0, DataOut=0, and the next request is accepted normally.
- Back-to-back fetches @0,4,8 sequenced the way the datapath's fetch loop issues them -> each response has correct data, and no request is accepted before MOC has fallen.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings for the MFA/MOC main memory: data types, access direction
// and the access-sequencing FSM states.
package mem_pkg;

    localparam logic [1:0] DT_BYTE = 2'b00;
    localparam logic [1:0] DT_HALF = 2'b01;
    localparam logic [1:0] DT_WORD = 2'b10;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/mem_align.sv
// Big-endian lane steering for byte/halfword/word accesses: builds the read
// word from the four bytes starting at the access address, picks write lanes,
// and flags misaligned halfword/word accesses.
module mem_align
    import mem_pkg::*;
(
    input  logic [1:0]  dt,
    input  logic        se,
    input  logic [1:0]  addr_lo,
    input  logic [7:0]  b0,
    input  logic [7:0]  b1,
    input  logic [7:0]  b2,
    input  logic [7:0]  b3,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [3:0]  wen,
    output logic [7:0]  w0,
    output logic [7:0]  w1,
    output logic [7:0]  w2,
    output logic [7:0]  w3,
    output logic        err
);

    // Lane i is the byte at address A+i; lane 0 is the most significant.
    always_comb begin
        rdata = 32'h0;
        wen   = 4'b0000;
        w0    = 8'h00;
        w1    = 8'h00;
        w2    = 8'h00;
        w3    = 8'h00;
        err   = 1'b0;
        case (dt)
            DT_BYTE: begin
                rdata = {{24{se & b0[7]}}, b0};
                wen   = 4'b0001;
                w0    = wdata[7:0];
            end
            DT_HALF: begin
                err   = addr_lo[0];
                rdata = {{16{se & b0[7]}}, b0, b1};
                wen   = 4'b0011;
                w0    = wdata[15:8];
                w1    = wdata[7:0];
            end
            default: begin
                err   = (addr_lo != 2'b00);
                rdata = {b0, b1, b2, b3};
                wen   = 4'b1111;
                w0    = wdata[31:24];
                w1    = wdata[23:16];
                w2    = wdata[15:8];
                w3    = wdata[7:0];
            end
        endcase
        if (err) begin
            wen = 4'b0000;
        end
    end

endmodule

// File: rtl/ram_mfa_moc.sv
// Byte-addressable big-endian main memory with an MFA/MOC handshake and a
// programmable access latency, used to exercise the control unit's wait states.
module ram_mfa_moc
    import mem_pkg::*;
#(
    parameter int ADDR_W  = 9,
    parameter int LATENCY = 2
) (
    input  logic              Clk,
    input  logic              Clear,
    input  logic              MFA,
    input  logic              RW,
    input  logic [1:0]        DT,
    input  logic              SE,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [31:0]       DataIn,
    output logic [31:0]       DataOut,
    output logic              MOC,
    output logic              Err
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [3:0] LAST_COUNT = 4'(LATENCY - 1);

    logic [7:0] Mem [0:DEPTH-1];

    state_t            state, state_d;
    logic [3:0]        count, count_d;
    logic [ADDR_W-1:0] addr_q;
    logic              rw_q, se_q;
    logic [1:0]        dt_q;
    logic [31:0]       din_q;
    logic              moc_d, err_d;
    logic [31:0]       dout_d;
    logic              latch_en, commit;

    logic [ADDR_W-1:0] a1, a2, a3;
    logic [31:0]       rdata;
    logic [3:0]        wen;
    logic [7:0]        w0, w1, w2, w3;
    logic              align_err;

    assign a1 = addr_q + ADDR_W'(1);
    assign a2 = addr_q + ADDR_W'(2);
    assign a3 = addr_q + ADDR_W'(3);

    mem_align u_align (
        .dt      (dt_q),
        .se      (se_q),
        .addr_lo (addr_q[1:0]),
        .b0      (Mem[addr_q]),
        .b1      (Mem[a1]),
        .b2      (Mem[a2]),
        .b3      (Mem[a3]),
        .wdata   (din_q),
        .rdata   (rdata),
        .wen     (wen),
        .w0      (w0),
        .w1      (w1),
        .w2      (w2),
        .w3      (w3),
        .err     (align_err)
    );

    always_comb begin
        state_d  = state;
        count_d  = count;
        moc_d    = MOC;
        err_d    = Err;
        dout_d   = DataOut;
        latch_en = 1'b0;
        commit   = 1'b0;
        case (state)
            S_IDLE: begin
                if (MFA) begin
                    latch_en = 1'b1;
                    count_d  = 4'd0;
                    state_d  = S_BUSY;
                end
            end
            S_BUSY: begin
                count_d = count + 4'd1;
                if (count == LAST_COUNT) begin
                    commit  = 1'b1;
                    moc_d   = 1'b1;
                    err_d   = align_err;
                    state_d = S_DONE;
                    if (rw_q == RW_READ && !align_err) begin
                        dout_d = rdata;
                    end
                end
            end
            S_DONE: begin
                if (!MFA) begin
                    moc_d   = 1'b0;
                    err_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Clear) begin
        if (Clear) begin
            state   <= S_IDLE;
            count   <= 4'd0;
            MOC     <= 1'b0;
            Err     <= 1'b0;
            DataOut <= 32'h0;
            addr_q  <= '0;
            rw_q    <= RW_READ;
            dt_q    <= DT_BYTE;
            se_q    <= 1'b0;
            din_q   <= 32'h0;
        end else begin
            state   <= state_d;
            count   <= count_d;
            MOC     <= moc_d;
            Err     <= err_d;
            DataOut <= dout_d;
            if (latch_en) begin
                addr_q <= Addr;
                rw_q   <= RW;
                dt_q   <= DT;
                se_q   <= SE;
                din_q  <= DataIn;
            end
        end
    end

    // Storage is never reset; commit only happens from BUSY, which Clear forces away.
    always_ff @(posedge Clk) begin
        if (commit && rw_q == RW_WRITE && !Clear) begin
            if (wen[0]) Mem[addr_q] <= w0;
            if (wen[1]) Mem[a1]     <= w1;
            if (wen[2]) Mem[a2]     <= w2;
            if (wen[3]) Mem[a3]     <= w3;
        end
    end

endmodule
